// File: rtl/if_fetch_stage_if.sv
// Bundles the instruction-memory req/ack port, the IF/ID register outputs and the
// ID/EX control inputs of the IF stage.
interface if_fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;

  modport master (
    input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, id_inst, id_pc, id_pc4, id_valid
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, id_inst, id_pc, id_pc4, id_valid
  );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I IF stage: owns the PC, fetches over a variable-latency req/ack port and
// loads the IF/ID register, with a one-entry skid for stalls and a drop state for redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_stage_if.master  bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   stale_pc_q, stale_pc_d;
  logic [XLEN-1:0]   skid_inst_q, skid_inst_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]   id_inst_q, id_inst_d;
  logic [XLEN-1:0]   id_pc_q, id_pc_d;
  logic [XLEN-1:0]   id_pc4_q, id_pc4_d;
  logic              id_valid_q, id_valid_d;
  logic              req_c;
  logic [XLEN-1:0]   addr_c;
  logic [XLEN-1:0]   redirect_tgt_c;

  assign redirect_tgt_c = bus.redirect_pc & ~XLEN'(3);

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      stale_pc_q  <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      id_inst_q   <= '0;
      id_pc_q     <= '0;
      id_pc4_q    <= '0;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stale_pc_q  <= stale_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
    end
  end

  // Next-state: redirect beats stall beats normal flow
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stale_pc_d  = stale_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    id_valid_d  = id_valid_q;
    req_c       = 1'b0;
    addr_c      = pc_q;

    unique case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (bus.redirect) begin
          id_inst_d   = '0;
          id_valid_d  = 1'b0;
          skid_inst_d = '0;
          skid_pc_d   = '0;
          pc_d        = redirect_tgt_c;
          if (!bus.imem_ack) begin
            stale_pc_d = pc_q;
            state_d    = DROP;
          end
        end else if (bus.stall) begin
          if (bus.imem_ack) begin
            skid_inst_d = bus.imem_rdata;
            skid_pc_d   = pc_q;
            pc_d        = pc_q + XLEN'(4);
            state_d     = HOLD;
          end
        end else if (bus.imem_ack) begin
          id_inst_d  = bus.imem_rdata;
          id_pc_d    = pc_q;
          id_pc4_d   = pc_q + XLEN'(4);
          id_valid_d = 1'b1;
          pc_d       = pc_q + XLEN'(4);
        end else begin
          id_inst_d  = '0;
          id_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (bus.redirect) begin
          id_inst_d   = '0;
          id_valid_d  = 1'b0;
          skid_inst_d = '0;
          skid_pc_d   = '0;
          pc_d        = redirect_tgt_c;
          state_d     = FETCH;
        end else if (!bus.stall) begin
          id_inst_d   = skid_inst_q;
          id_pc_d     = skid_pc_q;
          id_pc4_d    = skid_pc_q + XLEN'(4);
          id_valid_d  = 1'b1;
          skid_inst_d = '0;
          skid_pc_d   = '0;
          state_d     = FETCH;
        end
      end
      DROP: begin
        // Finish the abandoned request; its data never reaches IF/ID
        req_c  = 1'b1;
        addr_c = stale_pc_q;
        if (bus.redirect) pc_d = redirect_tgt_c;
        if (bus.imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.imem_req  = req_c & rst;
  assign bus.imem_addr = addr_c;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_pc4    = id_pc4_q;
  assign bus.id_valid  = id_valid_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a scoreboard of expected IF/ID contents
// is filled when the memory model acks and drained when the stage issues.
module tb_if_fetch_stage;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    sb.delete();
    tick(); tick();
    rst = 1'b1;
    #1;
  endtask

  // Pops one scoreboard entry and compares it with the IF/ID register
  task automatic check_issue(input string name);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got id_pc=%h, required a queued entry", name, bus.id_pc);
      return;
    end
    e = sb.pop_front();
    if (bus.id_valid !== 1'b1 || bus.id_inst !== e.inst || bus.id_pc !== e.pc || bus.id_pc4 !== e.pc + 32'd4)
      $display("FAIL %s: got v=%b inst=%h pc=%h pc4=%h, required v=1 inst=%h pc=%h pc4=%h",
               name, bus.id_valid, bus.id_inst, bus.id_pc, bus.id_pc4, e.inst, e.pc, e.pc + 32'd4);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    tick(); tick();
    n_total++;
    if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0)
      $display("FAIL reset_hold: got req=%b v=%b inst=%h, required 0 0 0", bus.imem_req, bus.id_valid, bus.id_inst);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0)
      $display("FAIL reset_release: got req=%b addr=%h, required 1 00000000", bus.imem_req, bus.imem_addr);
    else n_pass++;
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack = 1'b1;
      bus.imem_rdata = bus.imem_addr | 32'h13;
      sb.push_back('{inst: bus.imem_addr | 32'h13, pc: bus.imem_addr});
      tick();
      check_issue("zero_wait");
    end
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_wait_states();
    do_reset();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0013;
    sb.push_back('{inst: 32'h0000_0013, pc: 32'h0});
    tick();
    check_issue("wait_first");
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4)
        $display("FAIL wait_addr: got req=%b addr=%h, required 1 00000004", bus.imem_req, bus.imem_addr);
      else n_pass++;
      tick();
      n_total++;
      if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0)
        $display("FAIL wait_bubble: got v=%b inst=%h, required 0 00000000", bus.id_valid, bus.id_inst);
      else n_pass++;
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00A0_0093;
    sb.push_back('{inst: 32'h00A0_0093, pc: 32'h4});
    tick();
    bus.imem_ack = 1'b0;
    check_issue("wait_issue");
  endtask

  // Runs straight after test_wait_states: pc=0x8, IF/ID holds 0x4
  task automatic test_stall_skid();
    n_total++;
    if (bus.imem_addr !== 32'h8)
      $display("FAIL stall_addr: got addr=%h, required 00000008", bus.imem_addr);
    else n_pass++;
    bus.stall = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0010_0113;
    sb.push_back('{inst: 32'h0010_0113, pc: 32'h8});
    tick();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (bus.id_pc !== 32'h4 || bus.id_valid !== 1'b1 || bus.imem_req !== 1'b0)
        $display("FAIL stall_hold: got pc=%h v=%b req=%b, required 00000004 1 0", bus.id_pc, bus.id_valid, bus.imem_req);
      else n_pass++;
      if (i == 0) tick();
    end
    bus.stall = 1'b0;
    tick();
    check_issue("stall_release");
    n_total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC)
      $display("FAIL stall_next: got req=%b addr=%h, required 1 0000000c", bus.imem_req, bus.imem_addr);
    else n_pass++;
  endtask

  task automatic test_redirect_drop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack = 1'b1; bus.imem_rdata = bus.imem_addr | 32'h13;
      sb.push_back('{inst: bus.imem_addr | 32'h13, pc: bus.imem_addr});
      tick();
      check_issue("redir_prefill");
    end
    bus.imem_ack = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10)
        $display("FAIL redir_drop: got v=%b inst=%h req=%b addr=%h, required 0 00000000 1 00000010",
                 bus.id_valid, bus.id_inst, bus.imem_req, bus.imem_addr);
      else n_pass++;
      if (i == 0) tick();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    n_total++;
    if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0 || bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1)
      $display("FAIL redir_discard: got v=%b inst=%h req=%b addr=%h, required 0 00000000 1 00000100",
               bus.id_valid, bus.id_inst, bus.imem_req, bus.imem_addr);
    else n_pass++;
    bus.imem_rdata = 32'h0000_0113;
    sb.push_back('{inst: 32'h0000_0113, pc: 32'h100});
    tick();
    bus.imem_ack = 1'b0;
    check_issue("redir_target");
  endtask

  task automatic test_wrap_flush();
    do_reset();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h13;
    sb.push_back('{inst: 32'h13, pc: 32'h0});
    tick();
    check_issue("wrap_first");
    bus.redirect = 1'b1; bus.stall = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
    bus.imem_rdata = 32'hBAD0_0013;
    tick();
    bus.redirect = 1'b0; bus.stall = 1'b0;
    n_total++;
    if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_flush: got v=%b inst=%h req=%b addr=%h, required 0 00000000 1 fffffffc",
               bus.id_valid, bus.id_inst, bus.imem_req, bus.imem_addr);
    else n_pass++;
    bus.imem_rdata = 32'h0000_006F;
    sb.push_back('{inst: 32'h0000_006F, pc: 32'hFFFF_FFFC});
    tick();
    bus.imem_ack = 1'b0;
    check_issue("wrap_issue");
    n_total++;
    if (bus.imem_addr !== 32'h0 || bus.id_pc4 !== 32'h0)
      $display("FAIL wrap_addr: got addr=%h pc4=%h, required 00000000 00000000", bus.imem_addr, bus.id_pc4);
    else n_pass++;
  endtask

  // Random acks and stalls against a skid-tracking model
  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    logic        pend, st, ak, expect_out;
    do_reset();
    exp_addr = 32'h0;
    pend = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      st = ($urandom_range(0, 2) == 0);
      ak = 1'b0;
      expect_out = 1'b0;
      if (pend) begin
        n_total++;
        if (bus.imem_req !== 1'b0)
          $display("FAIL b2b_hold_req: got req=%b, required 0", bus.imem_req);
        else n_pass++;
        if (!st) begin expect_out = 1'b1; pend = 1'b0; end
      end else begin
        n_total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr)
          $display("FAIL b2b_addr: got req=%b addr=%h, required 1 %h", bus.imem_req, bus.imem_addr, exp_addr);
        else n_pass++;
        ak = ($urandom_range(0, 1) == 1);
        if (ak) begin
          bus.imem_rdata = $urandom;
          sb.push_back('{inst: bus.imem_rdata, pc: exp_addr});
          exp_addr = exp_addr + 32'd4;
          if (st) pend = 1'b1; else expect_out = 1'b1;
        end
      end
      bus.stall = st; bus.imem_ack = ak;
      tick();
      bus.imem_ack = 1'b0;
      if (expect_out) check_issue("b2b_issue");
      else if (!st) begin
        n_total++;
        if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0)
          $display("FAIL b2b_bubble: got v=%b inst=%h, required 0 00000000", bus.id_valid, bus.id_inst);
        else n_pass++;
      end
    end
    bus.stall = 1'b0;
    if (pend) begin
      tick();
      check_issue("b2b_drain");
    end
    n_total++;
    if (sb.size() != 0)
      $display("FAIL b2b_leftover: got %0d queued entries, required 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_skid();
    test_redirect_drop();
    test_wrap_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
